// File: rtl/lcd_controller.sv
// lcd_controller: HD44780-style 8-bit LCD write sequencer with valid/ready byte input.
// Define LCD_CTRL_INIT_SEQ_EN to run the power-up wait and 4-command init after every reset.
module lcd_controller #(
    parameter int PWRUP_CYC    = 750000,
    parameter int SETUP_CYC    = 4,
    parameter int E_HIGH_CYC   = 16,
    parameter int CMD_WAIT_CYC = 2500,
    parameter int CLR_WAIT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       init_done,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [7:0] LCD_DataBus
);
    localparam int MAX_A   = PWRUP_CYC > SETUP_CYC ? PWRUP_CYC : SETUP_CYC;
    localparam int MAX_B   = E_HIGH_CYC > CMD_WAIT_CYC ? E_HIGH_CYC : CMD_WAIT_CYC;
    localparam int MAX_C   = MAX_A > MAX_B ? MAX_A : MAX_B;
    localparam int MAX_CYC = MAX_C > CLR_WAIT_CYC ? MAX_C : CLR_WAIT_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    typedef enum logic [2:0] {PWRUP, SETUP, EHIGH, WAIT, IDLE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, wait_end;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d, e_q, e_d, ready_q, ready_d, done_q, done_d;
    logic          is_clr;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        return i == 2'd0 ? 8'h38 : i == 2'd1 ? 8'h0F : i == 2'd2 ? 8'h01 : 8'h06;
    endfunction

    // Clear and Home are the only commands needing the long execution wait
    assign is_clr   = !rs_q && data_q[7:2] == 6'd0 && data_q != 8'h00;
    assign wait_end = is_clr ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        rs_d    = rs_q;
        data_d  = data_q;
        e_d     = e_q;
        ready_d = ready_q;
        done_d  = done_q;
        case (state_q)
            PWRUP: begin
`ifdef LCD_CTRL_INIT_SEQ_EN
                if (cnt_q == CW'(PWRUP_CYC - 1)) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    rs_d    = 1'b0;
                    data_d  = init_cmd(2'd0);
                end
`else
                state_d = IDLE;
                ready_d = 1'b1;
                done_d  = 1'b1;
`endif
            end
            SETUP: if (cnt_q == CW'(SETUP_CYC - 1)) begin
                state_d = EHIGH;
                cnt_d   = '0;
                e_d     = 1'b1;
            end
            EHIGH: if (cnt_q == CW'(E_HIGH_CYC - 1)) begin
                state_d = WAIT;
                cnt_d   = '0;
                e_d     = 1'b0;
            end
            WAIT: if (cnt_q == wait_end) begin
                cnt_d = '0;
                if (!done_q && idx_q != 2'd3) begin
                    state_d = SETUP;
                    idx_d   = idx_q + 2'd1;
                    data_d  = init_cmd(idx_q + 2'd1);
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (in_valid) begin
                    state_d = SETUP;
                    rs_d    = in_rs;
                    data_d  = in_data;
                    ready_d = 1'b0;
                end
            end
            default: state_d = PWRUP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PWRUP;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            e_q     <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            e_q     <= e_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign in_ready    = ready_q;
    assign init_done   = done_q;
    assign LCD_RS      = rs_q;
    assign LCD_RW      = 1'b0;
    assign LCD_E       = e_q;
    assign LCD_DataBus = data_q;
endmodule
